// File: rtl/k051962_plane_shifter_pkg.sv
// Shared types and sizes for the k051962 per-layer pixel serializer.
// A pixel travels through the window as {palette, colour index}.
package k051962_pkg;

    localparam int TILE_W = 8;
    localparam int WIN_W  = 16;
    localparam int FINE_W = 3;

    typedef struct packed {
        logic [3:0] pal;
        logic [3:0] pix;
    } pixel_t;

endpackage

// File: rtl/k051962_plane_shifter_unpack.sv
// Splits one packed 4bpp tile row into eight pixels, tagging each with the tile
// palette and applying the combined per-tile / whole-screen horizontal flip.
module tile_nibble_unpack
    import k051962_pkg::*;
(
    input  logic [31:0]              ROM_D,
    input  logic [7:0]               COL,
    input  logic                     FLIPX_EN,
    input  logic                     FLIP_SCREEN,
    output pixel_t [TILE_W-1:0]      o_new
);

    logic w_flip;
    logic w_col_unused;

    // A screen flip mirrors every tile, so it cancels a per-tile flip.
    assign w_flip       = (COL[0] & FLIPX_EN) ^ FLIP_SCREEN;
    assign w_col_unused = ^COL[3:1];

    for (genvar j = 0; j < TILE_W; j++) begin : g_pix
        logic [3:0] w_fwd;
        logic [3:0] w_rev;
        assign w_fwd          = ROM_D[31-4*j -: 4];
        assign w_rev          = ROM_D[31-4*(TILE_W-1-j) -: 4];
        assign o_new[j].pal   = COL[7:4];
        assign o_new[j].pix   = w_flip ? w_rev : w_fwd;
    end

endmodule

// File: rtl/k051962_plane_shifter.sv
// 16-entry pixel window fed one tile at a time; the output tap position is the
// fine scroll latched at the last tile load, so larger FINE scrolls left.
module k051962_plane_shifter
    import k051962_pkg::*;
(
    input  logic              clk_24M,
    input  logic              nRES,
    input  logic              CE_6M,
    input  logic              LOAD,
    input  logic [31:0]       ROM_D,
    input  logic [7:0]        COL,
    input  logic              FLIPX_EN,
    input  logic              FLIP_SCREEN,
    input  logic [FINE_W-1:0] FINE,
    input  logic              HBLANK,
    output logic [3:0]        PIX,
    output logic [3:0]        PAL,
    output logic              OPAQUE
);

    pixel_t [WIN_W-1:0]  r_sr;
    pixel_t [TILE_W-1:0] w_new;
    pixel_t              w_tap;
    logic [FINE_W-1:0]   r_fine_q;
    logic [3:0]          r_pix;
    logic [3:0]          r_pal;
    logic                r_opaque;

    tile_nibble_unpack u_unpack (
        .ROM_D       (ROM_D),
        .COL         (COL),
        .FLIPX_EN    (FLIPX_EN),
        .FLIP_SCREEN (FLIP_SCREEN),
        .o_new       (w_new)
    );

    assign w_tap = r_sr[{1'b0, r_fine_q}];

    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            r_sr     <= '0;
            r_fine_q <= '0;
            r_pix    <= '0;
            r_pal    <= '0;
            r_opaque <= 1'b0;
        end else if (CE_6M) begin
            r_pix    <= HBLANK ? 4'd0 : w_tap.pix;
            r_pal    <= HBLANK ? 4'd0 : w_tap.pal;
            r_opaque <= ~HBLANK & (w_tap.pix != 4'd0);
            for (int i = 0; i < WIN_W-1; i++)
                r_sr[i] <= r_sr[i+1];
            r_sr[WIN_W-1] <= '0;
            // Loads still happen in blanking so the first visible tile is ready.
            if (LOAD) begin
                for (int j = 0; j < TILE_W; j++)
                    r_sr[TILE_W+j] <= w_new[j];
                r_fine_q <= FINE;
            end
        end
    end

    assign PIX    = r_pix;
    assign PAL    = r_pal;
    assign OPAQUE = r_opaque;

endmodule

// File: tb/tb_k051962_plane_shifter.sv
// Directed bench: two-tile streams with hand-ordered pixel sequences, checked per pixel tick.
module tb_k051962_plane_shifter;

    logic        clk_24M = 1'b0;
    logic        nRES = 1'b1;
    logic        CE_6M = 1'b0;
    logic        LOAD = 1'b0;
    logic [31:0] ROM_D = '0;
    logic [7:0]  COL = '0;
    logic        FLIPX_EN = 1'b0;
    logic        FLIP_SCREEN = 1'b0;
    logic [2:0]  FINE = '0;
    logic        HBLANK = 1'b0;
    logic [3:0]  PIX;
    logic [3:0]  PAL;
    logic        OPAQUE;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_24M = ~clk_24M;

    k051962_plane_shifter dut (
        .clk_24M(clk_24M), .nRES(nRES), .CE_6M(CE_6M), .LOAD(LOAD),
        .ROM_D(ROM_D), .COL(COL), .FLIPX_EN(FLIPX_EN), .FLIP_SCREEN(FLIP_SCREEN),
        .FINE(FINE), .HBLANK(HBLANK), .PIX(PIX), .PAL(PAL), .OPAQUE(OPAQUE)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One pixel tick: CE_6M high for one clk_24M cycle, then three idle cycles.
    task automatic tick(input logic ld);
        CE_6M = 1'b1;
        LOAD  = ld;
        @(posedge clk_24M); #1;
        CE_6M = 1'b0;
        LOAD  = 1'b0;
        repeat (3) @(posedge clk_24M);
        #1;
    endtask

    task automatic do_reset();
        nRES = 1'b0;
        #3;
        nRES = 1'b1;
    endtask

    // Expected {OPAQUE,PAL,PIX} after tick t. Tile 1 is loaded at tick 0 with FINE=f0,
    // tile 2 (all transparent, palette 0) at tick 8 with FINE=f1 or not at all.
    function automatic logic [8:0] model(input int t, input logic [31:0] order,
                                         input logic [7:0] col, input int f0,
                                         input int f1, input int hb_end);
        int fq;
        int k;
        logic [3:0] p;
        if (t < hb_end) return 9'd0;
        fq = (t == 0) ? 0 : ((t <= 8) ? f0 : f1);
        k  = fq + t - 9;
        if (t >= 1 && k >= 0 && k < 8) begin
            p = order[31-4*k -: 4];
            return {(p != 4'd0), col[7:4], p};
        end
        return 9'd0;
    endfunction

    task automatic run(input string nm, input logic [31:0] rom, input logic [7:0] col,
                       input logic fxen, input logic fs, input int f0, input int f1,
                       input int hb_end, input logic ld2, input logic stall,
                       input logic [31:0] order);
        logic [8:0] e;
        do_reset();
        FLIPX_EN    = fxen;
        FLIP_SCREEN = fs;
        for (int t = 0; t < 20; t++) begin
            ROM_D  = (t == 0) ? rom : 32'h0;
            COL    = (t == 0) ? col : 8'h00;
            FINE   = (t == 0) ? 3'(f0) : 3'(f1);
            HBLANK = (t < hb_end);
            tick((t == 0) || (t == 8 && ld2));
            e = model(t, order, col, f0, f1, hb_end);
            chk($sformatf("%s t%0d", nm, t), {23'd0, OPAQUE, PAL, PIX}, {23'd0, e});
            if (stall && t == 11) begin
                repeat (20) @(posedge clk_24M);
                #1;
                chk($sformatf("%s frozen", nm), {23'd0, OPAQUE, PAL, PIX}, {23'd0, e});
            end
        end
        HBLANK = 1'b0;
    endtask

    initial begin
        @(posedge clk_24M); #1;

        // Held in reset: nothing loads or leaves the window.
        nRES = 1'b0; ROM_D = 32'hFFFF_FFFF; COL = 8'hFF; FLIPX_EN = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick(1'b1);
            chk($sformatf("rst_hold t%0d", t), {23'd0, OPAQUE, PAL, PIX}, 32'h0);
        end
        nRES = 1'b1; FLIPX_EN = 1'b0;

        run("basic", 32'h1234_5678, 8'h50, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678);
        run("fine3", 32'h1234_5678, 8'h50, 0, 0, 3, 3, 0, 1, 0, 32'h1234_5678);
        run("fine7", 32'h1234_5678, 8'h50, 0, 0, 7, 7, 0, 1, 0, 32'h1234_5678);
        run("finechg", 32'h1234_5678, 8'h50, 0, 0, 0, 5, 0, 1, 0, 32'h1234_5678);
        run("flipx", 32'h1234_5678, 8'h31, 1, 0, 0, 0, 0, 1, 0, 32'h8765_4321);
        run("flipboth", 32'h1234_5678, 8'h31, 1, 1, 0, 0, 0, 1, 0, 32'h1234_5678);
        run("flipscr", 32'h1234_5678, 8'h30, 1, 1, 2, 2, 0, 1, 0, 32'h8765_4321);
        run("fxen0", 32'h1234_5678, 8'h31, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678);
        run("transp", 32'h0F0F_0F0F, 8'h50, 0, 0, 0, 0, 0, 1, 0, 32'h0F0F_0F0F);
        run("hblank", 32'h1234_5678, 8'h50, 0, 0, 0, 0, 10, 1, 0, 32'h1234_5678);
        run("noload", 32'h9ABC_DEF1, 8'hA0, 0, 0, 1, 1, 0, 0, 1, 32'h9ABC_DEF1);

        // Reset asserted mid-line clears outputs without waiting for an edge.
        do_reset();
        ROM_D = 32'h1234_5678; COL = 8'h50; FINE = 3'd0;
        tick(1'b1);
        ROM_D = 32'h0; COL = 8'h00;
        for (int t = 1; t <= 10; t++) tick(1'b0);
        chk("mid pre", {23'd0, OPAQUE, PAL, PIX}, 32'h152);
        #2 nRES = 1'b0;
        #1 chk("mid async", {23'd0, OPAQUE, PAL, PIX}, 32'h0);
        ROM_D = 32'hFFFF_FFFF;
        tick(1'b1);
        chk("mid held", {23'd0, OPAQUE, PAL, PIX}, 32'h0);
        nRES = 1'b1; ROM_D = 32'h0;
        for (int t = 0; t < 10; t++) begin
            tick(1'b0);
            chk($sformatf("mid after t%0d", t), {23'd0, OPAQUE, PAL, PIX}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
